matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
- Synthesizable sequencer for the 4x4 by 4x1 matrix-vector multiply built from four MAC lanes.
- Latches one matrix/vector job on a start handshake, then zeroes the MAC accumulators.
- Streams one column of A plus the matching X element per clock to all four lanes, waits out the MAC latency, and captures Y1..Y4.
- Presents the result behind a valid/ready handshake. It replaces the testbench-style initial-block sequencing and drives the four MAC instances directly.

Parameters:
- N, 32, operand width of every A element and X element; MAC results are 2N bits.
- MAC_LAT, 1, clocks from the last operand applied to the MAC until its out reflects it; legal range 1..4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- clear  input  1  synchronous, active-high reset
- start  input  1  job request; accepted only when busy=0
- busy  output  1  high from the cycle after acceptance until the result is transferred
- A1,A2,A3,A4  input  4N  matrix rows; bits [4N-1:3N] are column 0, [N-1:0] are column 3
- X1,X2,X3,X4  input  N  vector elements; X1 pairs with column 0
- mac_clear_n  output  1  active-low clear to all four MAC lanes
- mac_a1,mac_a2,mac_a3,mac_a4  output  N  A operand to MAC lanes 0..3
- mac_x  output  N  shared B operand to all lanes
- Y1_in,Y2_in,Y3_in,Y4_in  input  2N  MAC lane outputs
- Y1,Y2,Y3,Y4  output  2N  captured result registers
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- done  output  1  one-cycle pulse on result transfer (out_valid and out_ready)

Behaviour:
- Reset, clear=1 at a rising edge:
  - state=IDLE.
  - busy=0, out_valid=0, done=0, Y1..Y4=0.
  - mac_a*=0, mac_x=0, mac_clear_n=0.
  - Latched A/X registers=0, column counter k=0.
  - Reset overrides every other input in any state; a job in flight is abandoned with no done pulse.
- States: IDLE -> CLR -> ACC -> DRAIN -> HOLD -> IDLE.
- IDLE:
  - mac_clear_n=1, operands=0.
  - With start=1, latch A1..A4 and X1..X4 and go to CLR. Inputs may change after the acceptance cycle.
- CLR, 1 cycle:
  - mac_clear_n=0, operands=0, busy=1; go to ACC with k=0.
- ACC, 4 cycles, k=0..3:
  - mac_clear_n=1.
  - mac_aR = latched row R column k, i.e. slice [(4-k)*N-1:(3-k)*N].
  - mac_x = latched X(k+1).
  - k increments each cycle; after k=3 go to DRAIN.
- DRAIN, MAC_LAT cycles:
  - Operands=0 so the accumulators hold.
  - At the end of the last drain cycle, Y1..Y4 <= Y1_in..Y4_in; go to HOLD.
- HOLD:
  - out_valid=1. Y1..Y4 stay stable while out_valid=1 and out_ready=0.
  - When out_valid and out_ready are both 1 in the same cycle: done=1 in the next cycle, out_valid=0, busy=0, state=IDLE.
  - Y1..Y4 retain their values until the next capture.
- Start rules:
  - start is ignored whenever busy=1 or out_valid=1; no queuing.
  - A start in the same cycle as the HOLD transfer is ignored. It can be accepted from the following cycle, since IDLE is entered then.
- Latency: for start accepted in cycle T:
  - mac_clear_n=0 in T+1.
  - Operands for k=0..3 in T+2..T+5.
  - out_valid rises in T+6+MAC_LAT (T+7 at default).
  - Minimum job-to-job period is 7+MAC_LAT cycles with out_ready tied high.
- Arithmetic:
  - Unsigned. The controller does no arithmetic; Y = sum over k of A[R][k]*X[k], computed by the MACs.
  - Wraps modulo 2^(2N), no saturation or overflow flag.
- Every output is registered; no combinational path from any input to any output.

Test Plan:
- Identity job, N=8: A1=0x01000000, A2=0x00010000, A3=0x00000100, A4=0x00000001, X=1,2,3,4, out_ready=1 -> mac_clear_n=0 at T+1; mac_x=1,2,3,4 at T+2..T+5; out_valid at T+7 with Y=1,2,3,4; done pulse at T+8.
- Overflow, N=8, all A and X elements 255 -> Y1..Y4=63492 (260100 mod 65536).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> Y stable and start pulses ignored; out_ready=1 -> single done pulse, busy falls, next start accepted.
- Reset mid-job: clear=1 during ACC k=2 -> next cycle IDLE, all outputs 0, mac_clear_n=0, no done; a fresh job afterwards produces correct Y.
- Back-to-back with out_ready tied high, MAC_LAT=2: two jobs (identity, then A all 2 with X all 3 giving Y=24 each) -> second start accepted the cycle after the first done; results correct; start-to-start period 9 cycles.
- Input change after accept: alter A/X one cycle after start -> results match the latched values.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_seq_ctrl
//
// Sequencer for a 4x4 by 4x1 matrix-vector multiply built from four MAC
// lanes. One job (four matrix rows plus four vector elements) is latched on
// a start handshake. The controller then clears the MAC accumulators and
// streams one matrix column plus the matching vector element per clock. It
// waits out the MAC latency, captures the four lane results and offers them
// behind a valid/ready handshake.
//
// Ports:
//   clk                 system clock, rising edge
//   clear               synchronous active-high reset
//   start               job request, taken only while idle
//   busy                high from the cycle after acceptance until transfer
//   A1..A4   [4N]       matrix rows, [4N-1:3N] is column 0, [N-1:0] column 3
//   X1..X4   [N]        vector elements, X1 pairs with column 0
//   mac_clear_n         active-low accumulator clear to all four lanes
//   mac_a1..mac_a4 [N]  A operand per lane
//   mac_x    [N]        B operand shared by all lanes
//   Y1_in..Y4_in [2N]   MAC lane outputs
//   Y1..Y4   [2N]       captured results
//   out_valid           result available
//   out_ready           consumer accepts the result
//   done                one-cycle pulse after the result transfer
//
// All outputs are registered. The controller performs no arithmetic.
// ---------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int N       = 32,
    parameter int MAC_LAT = 1
) (
    input  logic           clk,
    input  logic           clear,
    input  logic           start,
    output logic           busy,
    input  logic [4*N-1:0] A1,
    input  logic [4*N-1:0] A2,
    input  logic [4*N-1:0] A3,
    input  logic [4*N-1:0] A4,
    input  logic [N-1:0]   X1,
    input  logic [N-1:0]   X2,
    input  logic [N-1:0]   X3,
    input  logic [N-1:0]   X4,
    output logic           mac_clear_n,
    output logic [N-1:0]   mac_a1,
    output logic [N-1:0]   mac_a2,
    output logic [N-1:0]   mac_a3,
    output logic [N-1:0]   mac_a4,
    output logic [N-1:0]   mac_x,
    input  logic [2*N-1:0] Y1_in,
    input  logic [2*N-1:0] Y2_in,
    input  logic [2*N-1:0] Y3_in,
    input  logic [2*N-1:0] Y4_in,
    output logic [2*N-1:0] Y1,
    output logic [2*N-1:0] Y2,
    output logic [2*N-1:0] Y3,
    output logic [2*N-1:0] Y4,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_ACC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Drain counter value on the last MAC latency cycle (MAC_LAT is 1..4).
    localparam logic [1:0] DRAIN_LAST = 2'(MAC_LAT - 1);

    state_t         state_r;
    logic [1:0]     k_r;
    logic [1:0]     drain_r;
    logic [4*N-1:0] a_r [4];
    logic [N-1:0]   x_r [4];
    logic [1:0]     op_k_s;

    // Pick column k out of a packed matrix row; column 0 sits in the top bits.
    function automatic logic [N-1:0] col_sel(input logic [4*N-1:0] row,
                                             input logic [1:0]     k);
        logic [N-1:0] col;
        case (k)
            2'd0:    col = row[4*N-1:3*N];
            2'd1:    col = row[3*N-1:2*N];
            2'd2:    col = row[2*N-1:N];
            2'd3:    col = row[N-1:0];
            default: col = '0;
        endcase
        return col;
    endfunction

    // Column whose operands are loaded at the coming edge: 0 when leaving
    // CLR, otherwise the one after the column currently on the lanes.
    always_comb begin
        if (state_r == ST_CLR) begin
            op_k_s = 2'd0;
        end else begin
            op_k_s = k_r + 2'd1;
        end
    end

    // Sequencer state, latched job, MAC drive and result registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r     <= ST_IDLE;
            k_r         <= 2'd0;
            drain_r     <= 2'd0;
            for (int r = 0; r < 4; r++) begin
                a_r[r] <= '0;
                x_r[r] <= '0;
            end
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            mac_clear_n <= 1'b0;
            mac_a1      <= '0;
            mac_a2      <= '0;
            mac_a3      <= '0;
            mac_a4      <= '0;
            mac_x       <= '0;
            Y1          <= '0;
            Y2          <= '0;
            Y3          <= '0;
            Y4          <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    mac_a1 <= '0;
                    mac_a2 <= '0;
                    mac_a3 <= '0;
                    mac_a4 <= '0;
                    mac_x  <= '0;
                    if (start) begin
                        a_r[0]      <= A1;
                        a_r[1]      <= A2;
                        a_r[2]      <= A3;
                        a_r[3]      <= A4;
                        x_r[0]      <= X1;
                        x_r[1]      <= X2;
                        x_r[2]      <= X3;
                        x_r[3]      <= X4;
                        mac_clear_n <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= ST_CLR;
                    end else begin
                        mac_clear_n <= 1'b1;
                    end
                end
                ST_CLR: begin
                    mac_clear_n <= 1'b1;
                    mac_a1      <= col_sel(a_r[0], op_k_s);
                    mac_a2      <= col_sel(a_r[1], op_k_s);
                    mac_a3      <= col_sel(a_r[2], op_k_s);
                    mac_a4      <= col_sel(a_r[3], op_k_s);
                    mac_x       <= x_r[op_k_s];
                    k_r         <= 2'd0;
                    state_r     <= ST_ACC;
                end
                ST_ACC: begin
                    if (k_r == 2'd3) begin
                        // Zero operands so the accumulators hold while draining.
                        mac_a1  <= '0;
                        mac_a2  <= '0;
                        mac_a3  <= '0;
                        mac_a4  <= '0;
                        mac_x   <= '0;
                        drain_r <= 2'd0;
                        state_r <= ST_DRAIN;
                    end else begin
                        mac_a1  <= col_sel(a_r[0], op_k_s);
                        mac_a2  <= col_sel(a_r[1], op_k_s);
                        mac_a3  <= col_sel(a_r[2], op_k_s);
                        mac_a4  <= col_sel(a_r[3], op_k_s);
                        mac_x   <= x_r[op_k_s];
                        k_r     <= op_k_s;
                    end
                end
                ST_DRAIN: begin
                    if (drain_r == DRAIN_LAST) begin
                        Y1        <= Y1_in;
                        Y2        <= Y2_in;
                        Y3        <= Y3_in;
                        Y4        <= Y4_in;
                        out_valid <= 1'b1;
                        state_r   <= ST_HOLD;
                    end else begin
                        drain_r   <= drain_r + 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet idle.
                    state_r     <= ST_IDLE;
                    busy        <= 1'b0;
                    out_valid   <= 1'b0;
                    mac_clear_n <= 1'b0;
                    mac_a1      <= '0;
                    mac_a2      <= '0;
                    mac_a3      <= '0;
                    mac_a4      <= '0;
                    mac_x       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//
// Two controller instances (MAC_LAT=1 and MAC_LAT=2, N=8) are each driven
// by a behavioural MAC model. Inputs are shared and each instance has its
// own clear, so only one is active at a time. Expected results are pushed to
// a scoreboard when a job is issued and popped when out_valid is seen.
// ---------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    localparam int N = 8;
    localparam int W = 2 * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           clear0, clear1, start, out_ready;
    logic [4*N-1:0] a1, a2, a3, a4;
    logic [N-1:0]   x1, x2, x3, x4;

    logic           busy0, mcn0, ov0, done0;
    logic [N-1:0]   ma0 [4];
    logic [N-1:0]   mx0;
    logic [W-1:0]   acc0 [4];
    logic [W-1:0]   y0 [4];

    logic           busy1, mcn1, ov1, done1;
    logic [N-1:0]   ma1 [4];
    logic [N-1:0]   mx1;
    logic [W-1:0]   acc1 [4];
    logic [W-1:0]   pipe1 [4];
    logic [W-1:0]   y1 [4];

    matmul_seq_ctrl #(.N(N), .MAC_LAT(1)) u_dut0 (
        .clk(clk), .clear(clear0), .start(start), .busy(busy0),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4),
        .X1(x1), .X2(x2), .X3(x3), .X4(x4),
        .mac_clear_n(mcn0),
        .mac_a1(ma0[0]), .mac_a2(ma0[1]), .mac_a3(ma0[2]), .mac_a4(ma0[3]),
        .mac_x(mx0),
        .Y1_in(acc0[0]), .Y2_in(acc0[1]), .Y3_in(acc0[2]), .Y4_in(acc0[3]),
        .Y1(y0[0]), .Y2(y0[1]), .Y3(y0[2]), .Y4(y0[3]),
        .out_valid(ov0), .out_ready(out_ready), .done(done0)
    );

    matmul_seq_ctrl #(.N(N), .MAC_LAT(2)) u_dut1 (
        .clk(clk), .clear(clear1), .start(start), .busy(busy1),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4),
        .X1(x1), .X2(x2), .X3(x3), .X4(x4),
        .mac_clear_n(mcn1),
        .mac_a1(ma1[0]), .mac_a2(ma1[1]), .mac_a3(ma1[2]), .mac_a4(ma1[3]),
        .mac_x(mx1),
        .Y1_in(pipe1[0]), .Y2_in(pipe1[1]), .Y3_in(pipe1[2]), .Y4_in(pipe1[3]),
        .Y1(y1[0]), .Y2(y1[1]), .Y3(y1[2]), .Y4(y1[3]),
        .out_valid(ov1), .out_ready(out_ready), .done(done1)
    );

    // One-cycle MAC lanes for instance 0.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!mcn0) acc0[i] <= '0;
            else       acc0[i] <= acc0[i] + W'(ma0[i]) * W'(mx0);
        end
    end

    // Two-cycle MAC lanes for instance 1 (accumulator plus output register).
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!mcn1) acc1[i] <= '0;
            else       acc1[i] <= acc1[i] + W'(ma1[i]) * W'(mx1);
            pipe1[i] <= acc1[i];
        end
    end

    logic         dsel = 1'b0;
    logic         ov_s;
    logic [W-1:0] y_s [4];
    always_comb begin
        ov_s = dsel ? ov1 : ov0;
        for (int i = 0; i < 4; i++) y_s[i] = dsel ? y1[i] : y0[i];
    end

    int errors = 0;
    int checks = 0;
    logic [4*W-1:0] exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] dot(input logic [4*N-1:0] row, input logic [4*N-1:0] xv);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < 4; k++)
            s = s + W'(row[(3-k)*N +: N]) * W'(xv[(3-k)*N +: N]);
        return s;
    endfunction

    task automatic push_exp();
        logic [4*N-1:0] xv;
        xv = {x1, x2, x3, x4};
        exp_q.push_back({dot(a1, xv), dot(a2, xv), dot(a3, xv), dot(a4, xv)});
    endtask

    task automatic issue(input logic [4*N-1:0] r1, input logic [4*N-1:0] r2,
                         input logic [4*N-1:0] r3, input logic [4*N-1:0] r4,
                         input logic [N-1:0] v1, input logic [N-1:0] v2,
                         input logic [N-1:0] v3, input logic [N-1:0] v4);
        a1 = r1; a2 = r2; a3 = r3; a4 = r4;
        x1 = v1; x2 = v2; x3 = v3; x4 = v4;
        start = 1'b1;
        push_exp();
    endtask

    task automatic issue_rand();
        issue($urandom, $urandom, $urandom, $urandom,
              N'($urandom), N'($urandom), N'($urandom), N'($urandom));
    endtask

    task automatic wait_valid(input string tag, output int at);
        int n;
        n = 0;
        while (ov_s !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        at = cyc;
        chk({tag, " out_valid"}, 64'(ov_s), 64'd1);
    endtask

    task automatic check_y(input string tag);
        logic [4*W-1:0] e;
        chk({tag, " scoreboard_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s Y%0d", tag, i + 1), 64'(y_s[i]), 64'(e[(3-i)*W +: W]));
        end
    endtask

    initial begin
        int t0;
        int tv;
        int seen;
        clear0 = 1'b1; clear1 = 1'b1; start = 1'b0; out_ready = 1'b1;
        a1 = '0; a2 = '0; a3 = '0; a4 = '0;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        step();
        step();

        // Reset state
        chk("rst busy", 64'(busy0), 64'd0);
        chk("rst out_valid", 64'(ov0), 64'd0);
        chk("rst done", 64'(done0), 64'd0);
        chk("rst mac_clear_n", 64'(mcn0), 64'd0);
        chk("rst mac_x", 64'(mx0), 64'd0);
        chk("rst mac_a1", 64'(ma0[0]), 64'd0);
        for (int i = 0; i < 4; i++) chk("rst Y", 64'(y0[i]), 64'd0);
        clear0 = 1'b0;
        step();
        chk("idle mac_clear_n", 64'(mcn0), 64'd1);

        // Identity job with cycle-exact timing (T = this cycle)
        issue(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001,
              8'd1, 8'd2, 8'd3, 8'd4);
        step();
        start = 1'b0;
        chk("id T+1 busy", 64'(busy0), 64'd1);
        chk("id T+1 mac_clear_n", 64'(mcn0), 64'd0);
        chk("id T+1 mac_x", 64'(mx0), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("id acc mac_x", 64'(mx0), 64'(k + 1));
            chk("id acc mac_clear_n", 64'(mcn0), 64'd1);
            chk("id acc lane diag", 64'(ma0[k]), 64'd1);
            chk("id acc lane offdiag", 64'(ma0[(k + 1) % 4]), 64'd0);
        end
        step();
        chk("id T+6 out_valid", 64'(ov0), 64'd0);
        chk("id T+6 mac_x", 64'(mx0), 64'd0);
        step();
        chk("id T+7 out_valid", 64'(ov0), 64'd1);
        check_y("identity");
        step();
        chk("id T+8 done", 64'(done0), 64'd1);
        chk("id T+8 busy", 64'(busy0), 64'd0);
        chk("id T+8 out_valid", 64'(ov0), 64'd0);
        step();
        chk("id T+9 done", 64'(done0), 64'd0);

        // Overflow: all 255 wraps modulo 2^16
        issue({4{8'hFF}}, {4{8'hFF}}, {4{8'hFF}}, {4{8'hFF}},
              8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step();
        start = 1'b0;
        wait_valid("ovf", tv);
        check_y("ovf");
        chk("ovf Y1 const", 64'(y0[0]), 64'd63492);
        step();
        chk("ovf done", 64'(done0), 64'd1);

        // Inputs changed the cycle after acceptance
        issue_rand();
        step();
        start = 1'b0;
        a1 = $urandom; a2 = $urandom; a3 = $urandom; a4 = $urandom;
        x1 = N'($urandom); x2 = N'($urandom); x3 = N'($urandom); x4 = N'($urandom);
        wait_valid("chg", tv);
        check_y("chg");
        step();

        // Backpressure with ignored start pulses
        out_ready = 1'b0;
        issue(32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10,
              8'd5, 8'd6, 8'd7, 8'd8);
        step();
        start = 1'b0;
        wait_valid("bp", tv);
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 0);
            step();
            chk("bp out_valid", 64'(ov0), 64'd1);
            chk("bp busy", 64'(busy0), 64'd1);
            chk("bp done", 64'(done0), 64'd0);
            chk("bp Y1 stable", 64'(y0[0]), 64'(exp_q[0][4*W-1 -: W]));
        end
        out_ready = 1'b1;
        start = 1'b1;
        check_y("bp");
        step();
        start = 1'b0;
        chk("bp done pulse", 64'(done0), 64'd1);
        chk("bp busy fall", 64'(busy0), 64'd0);
        step();
        chk("bp start at transfer ignored", 64'(busy0), 64'd0);
        chk("bp single done", 64'(done0), 64'd0);
        issue_rand();
        step();
        start = 1'b0;
        chk("bp next start accepted", 64'(busy0), 64'd1);
        wait_valid("bp2", tv);
        check_y("bp2");
        step();

        // Reset during ACC k=2
        issue(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001,
              8'd1, 8'd2, 8'd3, 8'd4);
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("rm at k=2 mac_x", 64'(mx0), 64'd3);
        clear0 = 1'b1;
        step();
        clear0 = 1'b0;
        void'(exp_q.pop_back());
        chk("rm busy", 64'(busy0), 64'd0);
        chk("rm out_valid", 64'(ov0), 64'd0);
        chk("rm done", 64'(done0), 64'd0);
        chk("rm mac_clear_n", 64'(mcn0), 64'd0);
        chk("rm mac_x", 64'(mx0), 64'd0);
        chk("rm mac_a3", 64'(ma0[2]), 64'd0);
        chk("rm Y1", 64'(y0[0]), 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done0 !== 1'b0 || ov0 !== 1'b0) seen++;
        end
        chk("rm no done/valid", 64'(seen), 64'd0);
        issue_rand();
        step();
        start = 1'b0;
        wait_valid("rm fresh", tv);
        check_y("rm fresh");
        step();
        chk("rm fresh done", 64'(done0), 64'd1);

        // Back-to-back on the MAC_LAT=2 instance, out_ready high
        clear0 = 1'b1;
        clear1 = 1'b0;
        dsel = 1'b1;
        step();
        step();
        issue(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001,
              8'd1, 8'd2, 8'd3, 8'd4);
        t0 = cyc;
        step();
        a1 = {4{8'd2}}; a2 = {4{8'd2}}; a3 = {4{8'd2}}; a4 = {4{8'd2}};
        x1 = 8'd3; x2 = 8'd3; x3 = 8'd3; x4 = 8'd3;
        push_exp();
        chk("b2b busy T+1", 64'(busy1), 64'd1);
        wait_valid("b2b job1", tv);
        chk("b2b job1 latency", 64'(tv - t0), 64'd8);
        check_y("b2b job1");
        step();
        chk("b2b done1", 64'(done1), 64'd1);
        chk("b2b busy low at done", 64'(busy1), 64'd0);
        step();
        start = 1'b0;
        chk("b2b second accepted", 64'(busy1), 64'd1);
        wait_valid("b2b job2", tv);
        chk("b2b job2 at T+17", 64'(tv - t0), 64'd17);
        check_y("b2b job2");
        step();
        chk("b2b done2", 64'(done1), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
